imem_loader: RTL and testbench

Write-side front end for the byte-addressed instruction memory. Accepts 32-bit instruction words from a host or testbench stream over a valid/ready handshake. Serialises each word into four big-endian byte writes: byte at address A is `[31:24]`, at A+3 is `[7:0]`, matching the order in which the fetch path reassembles instructions. Holds the processor core in reset while a program is being loaded.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 tb/tb_imem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the instruction-memory loader.
//   imem_ld_state_t : loader FSM states
//   BYTES_PER_WORD  : bytes per instruction word
//   IMEM_ADDR_W     : default instruction-memory byte-address width
//   be_byte()       : big-endian byte select (index 0 is bits [31:24])
package mips_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IMEM_ADDR_W    = 10;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWaitWord,
        StWr,
        StFinish
    } imem_ld_state_t;

    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        b = word[31:24];
        unique case (idx)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: write-side front end for the byte-addressed instruction memory.
// Accepts 32-bit words over a valid/ready handshake and writes each as four
// big-endian bytes (A = [31:24] .. A+3 = [7:0]). Holds the core in reset while loading.
//
// Ports:
//   CLK, RESET            clock; asynchronous active-high reset
//   START                 begin a load (sampled only when idle)
//   BASE_ADDR, NUM_WORDS  first byte address (bits [1:0] ignored), word count
//   WORD_VALID/DATA/READY host word stream handshake
//   MEM_WE/ADDR/WDATA     byte write port to instruction memory
//   CPU_HOLD              core held in reset while high
//   BUSY, DONE, ERROR     load in progress, one-cycle completion, sticky rejection
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [CNT_W-1:0]  NUM_WORDS,
    input  logic              WORD_VALID,
    input  logic [31:0]       WORD_DATA,
    output logic              WORD_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR
);

    // Range check is done 3 bits wider than the address so base + 4*count cannot wrap.
    localparam int unsigned     ExtW     = ADDR_W + 3;
    localparam logic [ExtW-1:0] MemBytes = ExtW'(1) << ADDR_W;

    imem_ld_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;          // byte address of the current word
    logic [CNT_W-1:0]  num_words_q, num_words_d;
    logic [CNT_W-1:0]  count_q, count_d;        // words fully written
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;            // byte currently on the write port

    logic              word_ready_q, word_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [ExtW-1:0]   end_addr;
    logic [1:0]        idx_nxt;
    logic [CNT_W-1:0]  count_nxt;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        num_words_d  = num_words_q;
        count_d      = count_q;
        word_d       = word_q;
        idx_d        = idx_q;
        word_ready_d = word_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;

        end_addr  = ExtW'(addr_q) + (ExtW'(num_words_q) << 2);
        idx_nxt   = idx_q + 2'd1;
        count_nxt = count_q + CNT_W'(1);

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    addr_d      = BASE_ADDR & ~ADDR_W'(3);
                    num_words_d = NUM_WORDS;
                    count_d     = '0;
                    idx_d       = '0;
                    cpu_hold_d  = 1'b1;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (num_words_q == '0) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = StFinish;
                end else if (end_addr > MemBytes) begin
                    // Rejected: core stays held.
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    word_ready_d = 1'b1;
                    state_d      = StWaitWord;
                end
            end
            StWaitWord: begin
                if (WORD_VALID && word_ready_q) begin
                    // Outputs are registered, so byte 0 is launched on the handshake edge.
                    word_d       = WORD_DATA;
                    idx_d        = 2'd0;
                    word_ready_d = 1'b0;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_wdata_d  = be_byte(WORD_DATA, 2'd0);
                    state_d      = StWr;
                end
            end
            StWr: begin
                if (idx_q != 2'd3) begin
                    idx_d       = idx_nxt;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q + ADDR_W'(idx_nxt);
                    mem_wdata_d = be_byte(word_q, idx_nxt);
                end else begin
                    count_d = count_nxt;
                    addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
                    if (count_nxt == num_words_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        state_d    = StFinish;
                    end else begin
                        word_ready_d = 1'b1;
                        state_d      = StWaitWord;
                    end
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            num_words_q  <= '0;
            count_q      <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            word_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_words_q  <= num_words_d;
            count_q      <= count_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            word_ready_q <= word_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign WORD_READY = word_ready_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign CPU_HOLD   = cpu_hold_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERROR      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Stimulus pushes expected byte
// writes and DONE events into queues; a negedge monitor pops and compares them.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [9:0]  BASE_ADDR = '0;
    logic [8:0]  NUM_WORDS = '0;
    logic        WORD_VALID = 1'b0;
    logic [31:0] WORD_DATA = '0;
    logic        WORD_READY, MEM_WE, CPU_HOLD, BUSY, DONE, ERROR;
    logic [9:0]  MEM_ADDR;
    logic [7:0]  MEM_WDATA;

    imem_loader #(.ADDR_W(10), .CNT_W(9)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_WORDS  (NUM_WORDS),
        .WORD_VALID (WORD_VALID),
        .WORD_DATA  (WORD_DATA),
        .WORD_READY (WORD_READY),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .CPU_HOLD   (CPU_HOLD),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERROR      (ERROR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;

    logic [9:0]  exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    bit          exp_done_err_q[$];
    int          exp_done_cyc_q[$];   // -1: one cycle after the last write
    logic [7:0]  model_mem[1024];
    logic [7:0]  dut_mem[1024];
    logic [31:0] wq[$];
    int we_cnt = 0;
    int done_cnt = 0;
    int last_we_cyc = 0;
    int start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every MEM_WE and DONE is checked against the queued expectations.
    initial begin : monitor
        logic [9:0] a;
        logic [7:0] d;
        bit         e;
        int         c;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (MEM_WE) begin
                    we_cnt++;
                    last_we_cyc = cyc;
                    if (exp_addr_q.size() == 0) begin
                        n_run++;
                        n_fail++;
                        $display("FAIL unexpected_we: got write 0x%0h @0x%0h, expected none",
                                 MEM_WDATA, MEM_ADDR);
                    end else begin
                        a = exp_addr_q.pop_front();
                        d = exp_data_q.pop_front();
                        chk("wr_addr", 32'(MEM_ADDR), 32'(a));
                        chk("wr_data", 32'(MEM_WDATA), 32'(d));
                    end
                    dut_mem[MEM_ADDR] = MEM_WDATA;
                end
                if (DONE) begin
                    done_cnt++;
                    if (exp_done_err_q.size() == 0) begin
                        n_run++;
                        n_fail++;
                        $display("FAIL unexpected_done: got DONE=1, expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_done_err_q.pop_front();
                        c = exp_done_cyc_q.pop_front();
                        chk("done_error", 32'(ERROR), 32'(e));
                        chk("done_hold", 32'(CPU_HOLD), 32'(e));
                        chk("done_busy", 32'(BUSY), 32'd1);
                        chk("done_cycle", cyc, (c < 0) ? last_we_cyc + 1 : c);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(WORD_READY), 32'd0);
        chk({tag, "_we"}, 32'(MEM_WE), 32'd0);
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'd0);
        chk({tag, "_wdata"}, 32'(MEM_WDATA), 32'd0);
        chk({tag, "_hold"}, 32'(CPU_HOLD), 32'd1);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_error"}, 32'(ERROR), 32'd0);
    endtask

    task automatic mem_compare(input string tag);
        int mm = 0;
        for (int a = 0; a < 1024; a++) if (dut_mem[a] !== model_mem[a]) mm++;
        chk(tag, mm, 0);
    endtask

    task automatic do_start(input logic [9:0] base, input int n);
        @(posedge CLK);
        #1;
        START = 1'b1;
        BASE_ADDR = base;
        NUM_WORDS = n[8:0];
        start_cyc = cyc;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        chk("start_busy", 32'(BUSY), 32'd1);
        chk("start_hold", 32'(CPU_HOLD), 32'd1);
        chk("start_err_clr", 32'(ERROR), 32'd0);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (WORD_READY) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_seen", 32'(ok), 32'd1);
    endtask

    // Reference: aligned base + 4*n must not exceed 1024; byte b of word i lands at
    // aligned + 4i + b and carries bits [31-8b -: 8].
    task automatic run_load(input logic [9:0] base, input int n, input int gap);
        int ab = int'(base) & ~3;
        bit err = (n != 0) && (ab + 4 * n > 1024);
        int w0 = we_cnt;
        int d0 = done_cnt;
        int nexp = 0;
        int hs_prev = 0;
        bit ok;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                for (int b = 0; b < 4; b++) begin
                    int addr = ab + 4 * i + b;
                    logic [7:0] v = 8'(wq[i] >> (24 - 8 * b));
                    exp_addr_q.push_back(10'(addr));
                    exp_data_q.push_back(v);
                    model_mem[addr] = v;
                    nexp++;
                end
            end
        end
        do_start(base, n);
        exp_done_err_q.push_back(err);
        exp_done_cyc_q.push_back((n == 0 || err) ? start_cyc + 2 : -1);
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                wait_ready(ok);
                if (!ok) break;
                if (i == 0) chk("ready_latency", cyc - start_cyc, 2);
                else if (gap == 0) chk("throughput", cyc - hs_prev, 5);
                if (i > 0) begin
                    for (int k = 0; k < gap; k++) begin
                        chk("ready_gap", 32'(WORD_READY), 32'd1);
                        @(negedge CLK);
                    end
                end
                WORD_VALID = 1'b1;
                WORD_DATA = wq[i];
                hs_prev = cyc;
                @(posedge CLK);
                #1;
                if (gap > 0 || i == n - 1) WORD_VALID = 1'b0;
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge CLK);
            #1;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(ok), 32'd1);
        @(negedge CLK);
        chk("busy_after_done", 32'(BUSY), 32'd0);
        chk("done_one_cycle", 32'(DONE), 32'd0);
        chk("error_sticky", 32'(ERROR), 32'(err));
        chk("hold_after_done", 32'(CPU_HOLD), 32'(err));
        chk("we_count", we_cnt - w0, nexp);
        chk("wr_queue_empty", exp_addr_q.size(), 0);
        mem_compare("mem_contents");
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] t1_exp[8];
        int w0;
        int d0;
        bit ok;
        for (int a = 0; a < 1024; a++) begin
            model_mem[a] = '0;
            dut_mem[a] = '0;
        end
        t1_exp[0] = 8'h00; t1_exp[1] = 8'h01; t1_exp[2] = 8'h10; t1_exp[3] = 8'h20;
        t1_exp[4] = 8'h00; t1_exp[5] = 8'h64; t1_exp[6] = 8'h28; t1_exp[7] = 8'h24;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("reset");
        RESET = 1'b0;

        // Two-word load, VALID held high.
        wq.delete();
        wq.push_back(32'h00011020);
        wq.push_back(32'h00642824);
        run_load(10'h000, 2, 0);
        for (int i = 0; i < 8; i++) chk("t1_byte", 32'(dut_mem[i]), 32'(t1_exp[i]));

        // Same load with a 3-cycle VALID gap between words.
        run_load(10'h000, 2, 3);

        // Zero words, then rejected overflow, then exact-fit boundary.
        wq.delete();
        run_load(10'h010, 0, 0);
        run_load(10'h3FC, 2, 0);
        wq.push_back(32'hCAFEF00D);
        run_load(10'h3FC, 1, 1);

        // Unaligned base is forced down to a word boundary.
        wq.delete();
        wq.push_back(32'hAABBCCDD);
        run_load(10'h007, 1, 0);
        chk("unaligned_b4", 32'(dut_mem[4]), 32'hAA);
        chk("unaligned_b7", 32'(dut_mem[7]), 32'hDD);

        // Reset during the third byte write: only two bytes land, no DONE.
        wq.delete();
        wq.push_back(32'h11223344);
        w0 = we_cnt;
        d0 = done_cnt;
        exp_addr_q.push_back(10'h040); exp_data_q.push_back(8'h11);
        exp_addr_q.push_back(10'h041); exp_data_q.push_back(8'h22);
        model_mem[10'h040] = 8'h11;
        model_mem[10'h041] = 8'h22;
        do_start(10'h040, 1);
        wait_ready(ok);
        WORD_VALID = 1'b1;
        WORD_DATA = wq[0];
        @(posedge CLK);
        #1;
        WORD_VALID = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLK);
            #1;
            if (we_cnt - w0 == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_two_writes", 32'(ok), 32'd1);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_we_count", we_cnt - w0, 2);
        chk("rst_queue_empty", exp_addr_q.size(), 0);
        mem_compare("rst_mem");
        chk("rst_hold", 32'(CPU_HOLD), 32'd1);
        run_load(10'h040, 1, 0);

        // Randomized loads: zero-length, overflowing and in-range.
        for (int it = 0; it < 24; it++) begin
            int kind = int'($urandom_range(0, 9));
            int n;
            int base;
            if (kind == 0) begin
                n = 0;
                base = int'($urandom_range(0, 1023));
            end else if (kind == 1) begin
                n = int'($urandom_range(1, 8));
                base = int'($urandom_range(1028 - 4 * n, 1023));
            end else begin
                n = int'($urandom_range(1, 6));
                base = int'($urandom_range(0, 1024 - 4 * n + 3));
            end
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_load(10'(base), n, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
